// File: rtl/aclk_pkg.sv
// rtl/aclk_pkg.sv - shared types and BCD helpers for the multi-alarm clock
package aclk_pkg;

  localparam int unsigned MIN_PER_DAY = 1440;

  typedef struct packed {
    logic [1:0] h1;
    logic [3:0] h0;
    logic [3:0] m1;
    logic [3:0] m0;
  } bcd_hm_t;

  typedef enum logic [1:0] {IDLE, ARMED, RINGING, SNOOZED} alarm_state_e;

  function automatic logic hm_valid(input bcd_hm_t t);
    return !(t.h1 == 2'd3) && !(t.h1 == 2'd2 && t.h0 > 4'd3) &&
           (t.h0 <= 4'd9) && (t.m1 <= 4'd5) && (t.m0 <= 4'd9);
  endfunction

  // Work in minutes-of-day so the 23:59 -> 00:00 wrap falls out of the modulo.
  function automatic bcd_hm_t hm_add_min(input bcd_hm_t t, input int unsigned add);
    int unsigned mins;
    int unsigned hh;
    int unsigned mm;
    bcd_hm_t     r;
    mins = (32'(t.h1) * 10 + 32'(t.h0)) * 60 + 32'(t.m1) * 10 + 32'(t.m0);
    mins = (mins + add) % MIN_PER_DAY;
    hh   = mins / 60;
    mm   = mins % 60;
    r.h1 = 2'(hh / 10);
    r.h0 = 4'(hh % 10);
    r.m1 = 4'(mm / 10);
    r.m0 = 4'(mm % 10);
    return r;
  endfunction

endpackage

// File: rtl/aclk_alarm_slot.sv
// rtl/aclk_alarm_slot.sv - one alarm slot: stored time, FSM, snooze target, ring timer
module aclk_alarm_slot
  import aclk_pkg::*;
#(
  parameter int unsigned SNOOZE_MIN = 5,
  parameter int unsigned RING_SEC   = 60
) (
  input  logic    clk_i,
  input  logic    reset_i,
  input  logic    load_i,
  input  bcd_hm_t load_hm_i,
  input  logic    load_en_i,
  input  logic    stop_i,
  input  logic    snooze_i,
  input  logic    sec_strobe_i,
  input  logic    min_strobe_i,
  input  bcd_hm_t cur_hm_i,
  output logic    ringing_next_o
);

  localparam logic [7:0] RING_LAST = 8'(RING_SEC - 1);

  alarm_state_e state_q, state_d;
  bcd_hm_t      alarm_hm_q, alarm_hm_d;
  bcd_hm_t      target_q, target_d;
  logic [7:0]   cnt_q, cnt_d;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      alarm_hm_q <= '0;
      target_q   <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      alarm_hm_q <= alarm_hm_d;
      target_q   <= target_d;
      cnt_q      <= cnt_d;
    end
  end

  // A load always wins: it rewrites the slot and cancels any ring or snooze.
  always_comb begin
    state_d    = state_q;
    alarm_hm_d = alarm_hm_q;
    target_d   = target_q;
    cnt_d      = cnt_q;
    if (load_i) begin
      alarm_hm_d = load_hm_i;
      state_d    = load_en_i ? ARMED : IDLE;
    end else begin
      unique case (state_q)
        ARMED: begin
          if (min_strobe_i && cur_hm_i == alarm_hm_q) begin
            state_d = RINGING;
            cnt_d   = '0;
          end
        end
        RINGING: begin
          if (stop_i) begin
            state_d = ARMED;
          end else if (snooze_i) begin
            state_d  = SNOOZED;
            target_d = hm_add_min(cur_hm_i, SNOOZE_MIN);
          end else if (sec_strobe_i) begin
            if (cnt_q == RING_LAST) state_d = ARMED;
            else                    cnt_d   = cnt_q + 8'd1;
          end
        end
        SNOOZED: begin
          if (stop_i) begin
            state_d = ARMED;
          end else if (min_strobe_i && cur_hm_i == target_q) begin
            state_d = RINGING;
            cnt_d   = '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    ringing_next_o = (state_d == RINGING);
  end

endmodule

// File: rtl/aclk_multi_alarm.sv
// rtl/aclk_multi_alarm.sv - BCD real-time clock with N alarm slots
module aclk_multi_alarm
  import aclk_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 10,
  parameter int unsigned N_ALARMS   = 4,
  parameter int unsigned SNOOZE_MIN = 5,
  parameter int unsigned RING_SEC   = 60,
  localparam int unsigned SEL_W     = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          H_in1,
  input  logic [3:0]          H_in0,
  input  logic [3:0]          M_in1,
  input  logic [3:0]          M_in0,
  input  logic                LD_time,
  input  logic                LD_alarm,
  input  logic [SEL_W-1:0]    alarm_sel,
  input  logic                alarm_en_in,
  input  logic                STOP_al,
  input  logic                snooze,
  output logic [1:0]          H_out1,
  output logic [3:0]          H_out0,
  output logic [3:0]          M_out1,
  output logic [3:0]          M_out0,
  output logic [3:0]          S_out1,
  output logic [3:0]          S_out0,
  output logic [N_ALARMS-1:0] alarm,
  output logic                alarm_any,
  output logic                load_err
);

  localparam int unsigned      DIV_W    = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [SEL_W:0]   N_LIM    = (SEL_W + 1)'(N_ALARMS);

  bcd_hm_t             hm_q, hm_d, in_hm;
  logic [3:0]          s1_q, s1_d, s0_q, s0_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic                tick, tick_q, min_strobe;
  logic                load_ok, ld_time_ok, ld_alarm_ok, load_err_q;
  logic [N_ALARMS-1:0] ring_next, alarm_q;
  logic                alarm_any_q;

  assign in_hm       = {H_in1, H_in0, M_in1, M_in0};
  assign load_ok     = hm_valid(in_hm) && (!LD_alarm || ({1'b0, alarm_sel} < N_LIM));
  assign ld_time_ok  = LD_time && load_ok;
  assign ld_alarm_ok = LD_alarm && load_ok;
  assign tick        = (div_q == DIV_LAST);
  // Slots compare against the registered time one cycle after the tick that produced it.
  assign min_strobe  = tick_q && (s1_q == 4'd0) && (s0_q == 4'd0);

  always_comb begin
    hm_d  = hm_q;
    s1_d  = s1_q;
    s0_d  = s0_q;
    div_d = tick ? '0 : div_q + 1'b1;
    if (tick) begin
      if (s0_q != 4'd9) begin
        s0_d = s0_q + 4'd1;
      end else begin
        s0_d = 4'd0;
        if (s1_q != 4'd5) begin
          s1_d = s1_q + 4'd1;
        end else begin
          s1_d = 4'd0;
          hm_d = hm_add_min(hm_q, 1);
        end
      end
    end
    if (ld_time_ok) begin
      hm_d  = in_hm;
      s1_d  = 4'd0;
      s0_d  = 4'd0;
      div_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hm_q        <= '0;
      s1_q        <= '0;
      s0_q        <= '0;
      div_q       <= '0;
      tick_q      <= 1'b0;
      load_err_q  <= 1'b0;
      alarm_q     <= '0;
      alarm_any_q <= 1'b0;
    end else begin
      hm_q        <= hm_d;
      s1_q        <= s1_d;
      s0_q        <= s0_d;
      div_q       <= div_d;
      tick_q      <= tick && !ld_time_ok;
      load_err_q  <= (LD_time || LD_alarm) && !load_ok;
      alarm_q     <= ring_next;
      alarm_any_q <= |ring_next;
    end
  end

  for (genvar i = 0; i < N_ALARMS; i++) begin : g_slot
    localparam logic [SEL_W-1:0] IDX = SEL_W'(i);
    aclk_alarm_slot #(
      .SNOOZE_MIN(SNOOZE_MIN),
      .RING_SEC  (RING_SEC)
    ) u_slot (
      .clk_i         (clk),
      .reset_i       (reset),
      .load_i        (ld_alarm_ok && (alarm_sel == IDX)),
      .load_hm_i     (in_hm),
      .load_en_i     (alarm_en_in),
      .stop_i        (STOP_al),
      .snooze_i      (snooze),
      .sec_strobe_i  (tick_q),
      .min_strobe_i  (min_strobe),
      .cur_hm_i      (hm_q),
      .ringing_next_o(ring_next[i])
    );
  end

  assign H_out1    = hm_q.h1;
  assign H_out0    = hm_q.h0;
  assign M_out1    = hm_q.m1;
  assign M_out0    = hm_q.m0;
  assign S_out1    = s1_q;
  assign S_out0    = s0_q;
  assign alarm     = alarm_q;
  assign alarm_any = alarm_any_q;
  assign load_err  = load_err_q;

endmodule

// File: tb/tb_aclk_multi_alarm.sv
// tb/tb_aclk_multi_alarm.sv - directed bench with a seconds-of-day reference model
module tb_aclk_multi_alarm;

  localparam int CLK_DIV = 10;
  localparam int N       = 4;
  localparam int SNZ     = 5;
  localparam int RING    = 60;

  localparam int ST_OFF  = 0;
  localparam int ST_ARM  = 1;
  localparam int ST_RING = 2;
  localparam int ST_SNZ  = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] H_in1 = '0;
  logic [3:0] H_in0 = '0, M_in1 = '0, M_in0 = '0;
  logic       LD_time = 1'b0, LD_alarm = 1'b0;
  logic [1:0] alarm_sel = '0;
  logic       alarm_en_in = 1'b0, STOP_al = 1'b0, snooze = 1'b0;
  logic [1:0] H_out1;
  logic [3:0] H_out0, M_out1, M_out0, S_out1, S_out0;
  logic [N-1:0] alarm;
  logic       alarm_any, load_err;
  logic [21:0] tout;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int mark = 0;

  // Reference model state: time as seconds of day, alarms as minutes of day.
  int sod, div;
  bit tick_last, m_err, cmp_en;
  int s_min[N], s_st[N], s_snz[N], s_left[N];

  always #5 clk = ~clk;

  aclk_multi_alarm #(
    .CLK_DIV(CLK_DIV), .N_ALARMS(N), .SNOOZE_MIN(SNZ), .RING_SEC(RING)
  ) dut (
    .clk(clk), .reset(reset),
    .H_in1(H_in1), .H_in0(H_in0), .M_in1(M_in1), .M_in0(M_in0),
    .LD_time(LD_time), .LD_alarm(LD_alarm), .alarm_sel(alarm_sel),
    .alarm_en_in(alarm_en_in), .STOP_al(STOP_al), .snooze(snooze),
    .H_out1(H_out1), .H_out0(H_out0), .M_out1(M_out1), .M_out0(M_out0),
    .S_out1(S_out1), .S_out0(S_out0),
    .alarm(alarm), .alarm_any(alarm_any), .load_err(load_err)
  );

  assign tout = {H_out1, H_out0, M_out1, M_out0, S_out1, S_out0};

  function automatic logic [21:0] tvec(input int hh, input int mm, input int ss);
    return {2'(hh / 10), 4'(hh % 10), 4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_step();
    bit bad, ok, min_edge, tick;
    int hm;
    cyc++;
    if (reset) begin
      sod = 0; div = 0; tick_last = 0; m_err = 0; cmp_en = 1;
      for (int i = 0; i < N; i++) begin
        s_min[i] = 0; s_st[i] = ST_OFF; s_snz[i] = 0; s_left[i] = 0;
      end
      return;
    end
    bad = (H_in1 == 2'd3) || (H_in1 == 2'd2 && H_in0 > 4'd3) || (H_in0 > 4'd9) ||
          (M_in1 > 4'd5) || (M_in0 > 4'd9) || (LD_alarm && int'(alarm_sel) >= N);
    ok = !bad;
    m_err = (LD_time || LD_alarm) && bad;
    hm = (int'(H_in1) * 10 + int'(H_in0)) * 60 + int'(M_in1) * 10 + int'(M_in0);
    min_edge = tick_last && (sod % 60 == 0);
    for (int i = 0; i < N; i++) begin
      if (LD_alarm && ok && int'(alarm_sel) == i) begin
        s_min[i] = hm;
        s_st[i]  = alarm_en_in ? ST_ARM : ST_OFF;
      end else if (s_st[i] == ST_ARM) begin
        if (min_edge && sod / 60 == s_min[i]) begin
          s_st[i] = ST_RING; s_left[i] = RING;
        end
      end else if (s_st[i] == ST_RING) begin
        if (STOP_al) s_st[i] = ST_ARM;
        else if (snooze) begin
          s_st[i] = ST_SNZ; s_snz[i] = (sod / 60 + SNZ) % 1440;
        end else if (tick_last) begin
          s_left[i]--;
          if (s_left[i] == 0) s_st[i] = ST_ARM;
        end
      end else if (s_st[i] == ST_SNZ) begin
        if (STOP_al) s_st[i] = ST_ARM;
        else if (min_edge && sod / 60 == s_snz[i]) begin
          s_st[i] = ST_RING; s_left[i] = RING;
        end
      end
    end
    tick = (div == CLK_DIV - 1);
    div = tick ? 0 : div + 1;
    if (tick) sod = (sod + 1) % 86400;
    tick_last = tick;
    if (LD_time && ok) begin
      sod = hm * 60; div = 0; tick_last = 0;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    logic [N-1:0] ea;
    @(negedge clk);
    if (cmp_en) begin
      for (int i = 0; i < N; i++) ea[i] = (s_st[i] == ST_RING);
      chk("time", 32'(tout), 32'(tvec(sod / 3600, (sod / 60) % 60, sod % 60)));
      chk("alarm", 32'(alarm), 32'(ea));
      chk("alarm_any", 32'(alarm_any), 32'(|ea));
      chk("load_err", 32'(load_err), 32'(m_err));
    end
  end

  task automatic do_load(input bit t, input bit a, input logic [1:0] sel, input bit en,
                         input logic [1:0] h1, input logic [3:0] h0,
                         input logic [3:0] m1, input logic [3:0] m0);
    H_in1 = h1; H_in0 = h0; M_in1 = m1; M_in0 = m0;
    alarm_sel = sel; alarm_en_in = en; LD_time = t; LD_alarm = a;
    @(negedge clk);
    LD_time = 1'b0; LD_alarm = 1'b0;
    mark = cyc;
  endtask

  task automatic pulse(input bit do_stop, input bit do_snooze);
    STOP_al = do_stop; snooze = do_snooze;
    @(negedge clk);
    STOP_al = 1'b0; snooze = 1'b0;
  endtask

  task automatic run_to(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  initial begin
    int m0;
    repeat (3) @(negedge clk);
    chk("rst_time", 32'(tout), 32'(tvec(0, 0, 0)));
    chk("rst_alarm", 32'({alarm_any, alarm}), 32'd0);
    chk("rst_err", 32'(load_err), 32'd0);
    reset = 1'b0;
    mark = cyc;
    run_to(mark + 1);
    chk("no_tick_yet", 32'(tout), 32'(tvec(0, 0, 0)));
    run_to(mark + 10);
    chk("first_tick", 32'(tout), 32'(tvec(0, 0, 1)));
    run_to(mark + 600);
    chk("t_000100", 32'(tout), 32'(tvec(0, 1, 0)));

    do_load(1, 0, 2'd0, 0, 2'd2, 4'd3, 4'd5, 4'd9);
    run_to(mark + 600);
    chk("wrap_day", 32'(tout), 32'(tvec(0, 0, 0)));

    do_load(1, 0, 2'd0, 0, 2'd2, 4'd4, 4'd0, 4'd0);
    chk("bad_h_err", 32'(load_err), 32'd1);
    chk("bad_h_time", 32'(tout), 32'(tvec(0, 0, 0)));
    @(negedge clk);
    chk("err_1cyc", 32'(load_err), 32'd0);
    do_load(0, 1, 2'd1, 1, 2'd0, 4'd7, 4'd6, 4'd0);
    chk("bad_m_err", 32'(load_err), 32'd1);

    do_load(0, 1, 2'd2, 1, 2'd0, 4'd7, 4'd3, 4'd0);
    do_load(1, 0, 2'd0, 0, 2'd0, 4'd7, 4'd2, 4'd9);
    run_to(mark + 600);
    chk("t_0730", 32'(tout), 32'(tvec(7, 30, 0)));
    chk("ring2_pre", 32'(alarm), 32'b0000);
    run_to(mark + 601);
    chk("ring2", 32'({alarm_any, alarm}), 32'b10100);
    run_to(mark + 1200);
    chk("ring2_hold", 32'(alarm), 32'b0100);
    run_to(mark + 1201);
    chk("ring2_auto", 32'(alarm), 32'b0000);

    do_load(0, 1, 2'd0, 1, 2'd2, 4'd3, 4'd5, 4'd8);
    do_load(1, 0, 2'd0, 0, 2'd2, 4'd3, 4'd5, 4'd7);
    m0 = mark;
    run_to(m0 + 601);
    chk("ring0", 32'(alarm), 32'b0001);
    run_to(m0 + 650);
    pulse(0, 1);
    chk("snooze0", 32'(alarm), 32'b0000);
    run_to(m0 + 3600);
    chk("t_0003", 32'(tout), 32'(tvec(0, 3, 0)));
    run_to(m0 + 3601);
    chk("resnooze0", 32'(alarm), 32'b0001);
    run_to(m0 + 3700);
    pulse(1, 0);
    chk("stop0", 32'(alarm), 32'b0000);
    run_to(m0 + 6601);
    chk("t_0008", 32'(tout), 32'(tvec(0, 8, 0)));
    chk("no_ring_0008", 32'(alarm), 32'b0000);

    do_load(0, 1, 2'd0, 1, 2'd0, 4'd6, 4'd0, 4'd0);
    do_load(0, 1, 2'd1, 1, 2'd0, 4'd6, 4'd0, 4'd0);
    do_load(1, 0, 2'd0, 0, 2'd0, 4'd5, 4'd5, 4'd9);
    run_to(mark + 601);
    chk("ring01", 32'(alarm), 32'b0011);
    pulse(1, 1);
    chk("stop_wins", 32'(alarm), 32'b0000);
    run_to(mark + 3610);
    chk("no_snooze_ring", 32'(alarm), 32'b0000);

    do_load(1, 0, 2'd0, 0, 2'd0, 4'd5, 4'd5, 4'd9);
    run_to(mark + 601);
    chk("ring01_again", 32'(alarm), 32'b0011);
    do_load(0, 1, 2'd1, 0, 2'd0, 4'd6, 4'd0, 4'd0);
    chk("reload_off", 32'(alarm), 32'b0001);
    pulse(1, 0);
    do_load(1, 0, 2'd0, 0, 2'd0, 4'd5, 4'd5, 4'd9);
    run_to(mark + 601);
    chk("slot1_silent", 32'(alarm), 32'b0001);

    reset = 1'b1;
    @(negedge clk);
    chk("midring_rst", 32'({alarm_any, alarm}), 32'd0);
    chk("midring_rst_t", 32'(tout), 32'(tvec(0, 0, 0)));
    reset = 1'b0;

    do_load(1, 1, 2'd3, 1, 2'd1, 4'd2, 4'd0, 4'd0);
    chk("dual_load_t", 32'(tout), 32'(tvec(12, 0, 0)));
    run_to(mark + 30);
    chk("dual_no_ring", 32'(alarm), 32'b0000);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
